ogege_scan_gen: RTL and testbench
=================================

# ogege_scan_gen

Parametrised video scan generator for the graphics generator. It produces VGA-class timing from the system clock, using a pixel clock-enable instead of a derived clock. It adds text-cell scan counters for character renderers, a pixel-replication scale mode, a frame counter, and a sticky vblank interrupt with acknowledge. It replaces the fixed 640x480 timing core and the ad-hoc glyph/text row counters in the top level.

## Interface

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths in pixels
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths in lines
- HSZ / VSZ, 10 / 10, widths of the horizontal and vertical counters
- CLK_DIV, 4, clk_i cycles per pixel (≥1)
- CELL_W_LOG2 / CELL_H_LOG2, 3 / 3, log2 of the glyph cell width and height
- HSYNC_POL / VSYNC_POL, 0 / 0, asserted level of each sync output

Ports:
- clk_i, in, 1, system clock; the only clock
- rstn_i, in, 1, asynchronous active-low reset
- en_i, in, 1, run enable; when low, counters hold
- scale_i, in, 2, pixel replication: 0=x1, 1=x2, 2=x4, 3=reserved (treated as x1)
- irq_ack_i, in, 1, clears vblank_irq_o
- pix_ce_o, out, 1, one-cycle pixel strobe
- hcount_o, out, HSZ, raw horizontal position
- vcount_o, out, VSZ, raw vertical position
- de_o, out, 1, active-video flag
- hsync_o, out, 1, horizontal sync
- vsync_o, out, 1, vertical sync
- cell_col_o, out, CELL_W_LOG2, pixel column within the cell
- glyph_row_o, out, CELL_H_LOG2, row within the glyph
- text_col_o, out, HSZ-CELL_W_LOG2, text column
- text_row_o, out, VSZ-CELL_H_LOG2, text row
- line_start_o, out, 1, one-pixel pulse when hcount=0
- frame_start_o, out, 1, one-pixel pulse when hcount=0 and vcount=0
- vblank_irq_o, out, 1, sticky interrupt
- frame_cnt_o, out, 16, frames completed

## Operation

- **Divider.** A divider counts 0..CLK_DIV-1 while en_i=1. pix_ce_o=1 in the cycle where the divider equals CLK_DIV-1. With CLK_DIV=1, pix_ce_o follows en_i.
- **Raster counters.** On each pix_ce, hcount advances. It wraps at H_TOTAL-1 = H_ACTIVE+H_FP+H_SYNC+H_BP-1. On wrap, vcount advances and wraps at V_TOTAL-1.
- **Active video.** de = (hcount < H_ACTIVE) and (vcount < V_ACTIVE).
- **Sync.** hsync is asserted for H_ACTIVE+H_FP ≤ hcount < H_ACTIVE+H_FP+H_SYNC, at level HSYNC_POL. vsync follows the same rule on vcount with the V parameters.
- **Scale latch.** The scale factor is latched from scale_i only when frame_start is generated, so a change never tears a frame.
- **Logical coordinates.** lx = hcount >> scale and ly = vcount >> scale. cell_col = lx[CELL_W_LOG2-1:0] and text_col = lx >> CELL_W_LOG2. glyph_row and text_row come from ly in the same way. These are driven as zero outside the active area.
- **Vblank interrupt.** When vcount goes from V_ACTIVE-1 to V_ACTIVE (at hcount wrap), vblank_irq_o is set and frame_cnt increments, wrapping modulo 2^16.
  - irq_ack_i clears vblank_irq_o.
  - If a set and an ack occur in the same cycle, the set wins.
- **Enable low.** When en_i=0, every counter holds, pix_ce_o=0, all pulses are 0, and the level outputs keep their values. irq_ack_i is still honoured.

## Timing

- All outputs are registered and mutually aligned.
- Values for raster position N appear on the clk_i edge after the pix_ce that advanced to N. They are stable for CLK_DIV cycles.
- line_start_o and frame_start_o are high for exactly one clk_i cycle, coincident with pix_ce_o.
- Reset values:
  - all counters 0, pix_ce_o=0, de_o=0
  - hsync_o = ~HSYNC_POL, vsync_o = ~VSYNC_POL
  - pulses 0, vblank_irq_o=0, frame_cnt_o=0, latched scale = x1
- A reset asserted mid-frame returns everything to the reset state asynchronously. The first pix_ce after release occurs CLK_DIV cycles later and advances hcount to 1. Position (0,0) is the post-reset state, with frame_start not pulsed.
- irq_ack_i takes effect on the next edge.

## Structure

- A shared package ogege_video_pkg holds:
  - the default 640x480@60 timing constants
  - the scale-mode encoding (SCALE_X1/X2/X4)
  - the H_TOTAL/V_TOTAL derivation functions
- One natural sub-module, ogege_scan_axis: a single parametrised counter with sync/active decode, instantiated once for H and once for V. The V instance is advanced by the H wrap.

## Test plan

- **Tiny timing.** Use H 8/1/2/1, V 4/1/1/1, CLK_DIV=2, 3 frames → hcount wraps 11→0 every 24 clocks, and vcount wraps at 6. hsync is low only at hcount=9,10. frame_cnt=3 and frame_start pulses 3 times.
- **Default 640x480, CLK_DIV=4.** One frame → 800x525 pixels = 1,680,000 clocks. 480 lines have 640 de pixels each. vblank_irq_o rises at vcount=480, hcount=0.
- **Scale x2 requested mid-frame.** → cell counters stay x1 until the next frame_start. After it, hcount=16 gives text_col=1 and cell_col=0, and vcount=17 gives glyph_row=0 and text_row=1.
- **IRQ handshake.** Hold irq_ack_i high during the set cycle → irq stays 1. Ack one cycle later → irq 0 next edge. Without an ack, irq stays 1 across frames and frame_cnt still increments.
- **en_i low for 50 clocks at hcount=100** → no pix_ce, hcount remains 100. It resumes 101 CLK_DIV cycles after en_i returns.
- **Reset mid-line at hcount=300** → all outputs take their reset values immediately. hcount=1 appears CLK_DIV cycles after release.

Source files
------------

// File: rtl/ogege_video_pkg.sv
// Shared video timing constants, scale-mode encoding and raster-total helpers
// for the graphics generator's scan path.
package ogege_video_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Encoding equals the right-shift applied to raster coordinates.
  typedef enum logic [1:0] {
    SCALE_X1 = 2'd0,
    SCALE_X2 = 2'd1,
    SCALE_X4 = 2'd2
  } scale_e;

  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return axis_total(active, fp, sync, bp);
  endfunction

  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return axis_total(active, fp, sync, bp);
  endfunction

  function automatic scale_e scale_decode(input logic [1:0] s);
    case (s)
      2'd1:    return SCALE_X2;
      2'd2:    return SCALE_X4;
      default: return SCALE_X1;
    endcase
  endfunction

endpackage

// File: rtl/ogege_scan_axis.sv
// One raster axis: position counter plus active/sync decode of the position
// that will be held after the current edge.
module ogege_scan_axis import ogege_video_pkg::*; #(
  parameter int   ACTIVE = DEF_H_ACTIVE,
  parameter int   FP     = DEF_H_FP,
  parameter int   SYNC   = DEF_H_SYNC,
  parameter int   BP     = DEF_H_BP,
  parameter int   SZ     = 10,
  parameter logic POL    = 1'b0
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          adv,
  output logic [SZ-1:0] cnt,
  output logic [SZ-1:0] nxt,
  output logic          wrap,
  output logic          act_nxt,
  output logic          sync
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

  logic sync_nxt;

  assign wrap     = (cnt == SZ'(TOTAL - 1));
  assign nxt      = !adv ? cnt : (wrap ? '0 : cnt + 1'b1);
  assign act_nxt  = (nxt < SZ'(ACTIVE));
  assign sync_nxt = (nxt >= SZ'(ACTIVE + FP)) && (nxt < SZ'(ACTIVE + FP + SYNC));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt  <= '0;
      sync <= ~POL;
    end else begin
      cnt  <= nxt;
      sync <= sync_nxt ? POL : ~POL;
    end
  end

endmodule

// File: rtl/ogege_scan_gen.sv
// Video scan generator: clock-enable pixel divider, H/V raster axes, text-cell
// coordinates with per-frame pixel replication, frame counter and vblank irq.
module ogege_scan_gen import ogege_video_pkg::*; #(
  parameter int   H_ACTIVE    = DEF_H_ACTIVE,
  parameter int   H_FP        = DEF_H_FP,
  parameter int   H_SYNC      = DEF_H_SYNC,
  parameter int   H_BP        = DEF_H_BP,
  parameter int   V_ACTIVE    = DEF_V_ACTIVE,
  parameter int   V_FP        = DEF_V_FP,
  parameter int   V_SYNC      = DEF_V_SYNC,
  parameter int   V_BP        = DEF_V_BP,
  parameter int   HSZ         = 10,
  parameter int   VSZ         = 10,
  parameter int   CLK_DIV     = 4,
  parameter int   CELL_W_LOG2 = 3,
  parameter int   CELL_H_LOG2 = 3,
  parameter logic HSYNC_POL   = 1'b0,
  parameter logic VSYNC_POL   = 1'b0
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       en_i,
  input  logic [1:0]                 scale_i,
  input  logic                       irq_ack_i,
  output logic                       pix_ce_o,
  output logic [HSZ-1:0]             hcount_o,
  output logic [VSZ-1:0]             vcount_o,
  output logic                       de_o,
  output logic                       hsync_o,
  output logic                       vsync_o,
  output logic [CELL_W_LOG2-1:0]     cell_col_o,
  output logic [CELL_H_LOG2-1:0]     glyph_row_o,
  output logic [HSZ-CELL_W_LOG2-1:0] text_col_o,
  output logic [VSZ-CELL_H_LOG2-1:0] text_row_o,
  output logic                       line_start_o,
  output logic                       frame_start_o,
  output logic                       vblank_irq_o,
  output logic [15:0]                frame_cnt_o
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0]  div;
  logic           adv, h_wrap, v_wrap, h_act, v_act, de_nxt, fstart, vb_set;
  logic [HSZ-1:0] h_nxt, lx;
  logic [VSZ-1:0] v_cnt, v_nxt, ly;
  scale_e         scale_q, scale_eff;
  logic [1:0]     sh;

  assign adv = en_i && (div == DW'(CLK_DIV - 1));

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)   div <= '0;
    else if (en_i) div <= adv ? '0 : div + 1'b1;
  end

  ogege_scan_axis #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .SZ(HSZ), .POL(HSYNC_POL)
  ) u_h (
    .clk(clk_i), .rstn(rstn_i), .adv(adv),
    .cnt(hcount_o), .nxt(h_nxt), .wrap(h_wrap), .act_nxt(h_act), .sync(hsync_o)
  );

  ogege_scan_axis #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .SZ(VSZ), .POL(VSYNC_POL)
  ) u_v (
    .clk(clk_i), .rstn(rstn_i), .adv(adv && h_wrap),
    .cnt(v_cnt), .nxt(v_nxt), .wrap(v_wrap), .act_nxt(v_act), .sync(vsync_o)
  );

  assign vcount_o = v_cnt;
  assign fstart   = adv && h_wrap && v_wrap;
  assign vb_set   = adv && h_wrap && (v_cnt == VSZ'(V_ACTIVE - 1));
  assign de_nxt   = h_act && v_act;

  // The new scale applies from the frame_start pixel onward, never mid-frame.
  assign scale_eff = fstart ? scale_decode(scale_i) : scale_q;
  assign sh        = scale_eff;
  assign lx        = h_nxt >> sh;
  assign ly        = v_nxt >> sh;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pix_ce_o      <= 1'b0;
      line_start_o  <= 1'b0;
      frame_start_o <= 1'b0;
      de_o          <= 1'b0;
      cell_col_o    <= '0;
      glyph_row_o   <= '0;
      text_col_o    <= '0;
      text_row_o    <= '0;
      scale_q       <= SCALE_X1;
      vblank_irq_o  <= 1'b0;
      frame_cnt_o   <= '0;
    end else begin
      pix_ce_o      <= adv;
      line_start_o  <= adv && h_wrap;
      frame_start_o <= fstart;
      scale_q       <= scale_eff;
      if (adv) begin
        de_o        <= de_nxt;
        cell_col_o  <= de_nxt ? lx[CELL_W_LOG2-1:0]   : '0;
        text_col_o  <= de_nxt ? lx[HSZ-1:CELL_W_LOG2] : '0;
        glyph_row_o <= de_nxt ? ly[CELL_H_LOG2-1:0]   : '0;
        text_row_o  <= de_nxt ? ly[VSZ-1:CELL_H_LOG2] : '0;
      end
      if (vb_set) begin
        vblank_irq_o <= 1'b1;
        frame_cnt_o  <= frame_cnt_o + 16'd1;
      end else if (irq_ack_i) begin
        vblank_irq_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ogege_scan_gen.sv
// Directed bench for ogege_scan_gen on a small 40x30 raster (32x24 active, CLK_DIV=2).
module tb_ogege_scan_gen;

  localparam int HSZ = 10, VSZ = 10, CW = 3, CH = 3;

  logic clk = 1'b0, rstn = 1'b0, en = 1'b0, ack = 1'b0;
  logic [1:0] scale = 2'd0;
  logic pix_ce, de, hsync, vsync, line_start, frame_start, irq;
  logic [HSZ-1:0] hcount;
  logic [VSZ-1:0] vcount;
  logic [CW-1:0] cell_col;
  logic [CH-1:0] glyph_row;
  logic [HSZ-CW-1:0] text_col;
  logic [VSZ-CH-1:0] text_row;
  logic [15:0] frame_cnt;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  ogege_scan_gen #(
    .H_ACTIVE(32), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(24), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .HSZ(HSZ), .VSZ(VSZ), .CLK_DIV(2), .CELL_W_LOG2(CW), .CELL_H_LOG2(CH),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dut (
    .clk_i(clk), .rstn_i(rstn), .en_i(en), .scale_i(scale), .irq_ack_i(ack),
    .pix_ce_o(pix_ce), .hcount_o(hcount), .vcount_o(vcount), .de_o(de),
    .hsync_o(hsync), .vsync_o(vsync), .cell_col_o(cell_col), .glyph_row_o(glyph_row),
    .text_col_o(text_col), .text_row_o(text_row), .line_start_o(line_start),
    .frame_start_o(frame_start), .vblank_irq_o(irq), .frame_cnt_o(frame_cnt)
  );

  task automatic wait_pos(input int h, input int v, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (pix_ce && int'(hcount) == h && int'(vcount) == v) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; en = 1'b0; ack = 1'b0; scale = 2'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({hcount, vcount, pix_ce, de, hsync, vsync, line_start, frame_start, irq, frame_cnt} !==
        {10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0}) begin
      failures++;
      $display("FAIL reset_state actual h=%0d v=%0d ce=%b de=%b hs=%b vs=%b ls=%b fs=%b irq=%b fc=%0d required all 0 with hs=vs=1",
               hcount, vcount, pix_ce, de, hsync, vsync, line_start, frame_start, irq, frame_cnt);
    end
    checks++;
    if ({cell_col, glyph_row, text_col, text_row} !== 20'd0) begin
      failures++;
      $display("FAIL reset_cells actual %h required 0", {cell_col, glyph_row, text_col, text_row});
    end
  endtask

  // Three full frames from reset release, every cycle compared against a position model.
  task automatic test_frames();
    logic [62:0] act, exp, fa, fe;
    int bad, first_k, fs_cnt, n, eh, ev, fcx;
    logic pce, dex;
    bad = 0; first_k = 0; fs_cnt = 0; fa = '0; fe = '0;
    rstn = 1'b1; en = 1'b1;
    for (int k = 1; k <= 7200; k++) begin
      @(negedge clk);
      pce = (k % 2 == 0);
      n   = k / 2;
      eh  = n % 40;
      ev  = (n / 40) % 30;
      dex = (n != 0) && eh < 32 && ev < 24;
      fcx = (n < 960) ? 0 : (n - 960) / 1200 + 1;
      exp = {pce, 10'(eh), 10'(ev), dex, !(eh >= 34 && eh < 37), !(ev >= 26 && ev < 28),
             pce && eh == 0, pce && eh == 0 && ev == 0,
             dex ? 3'(eh % 8) : 3'd0, dex ? 3'(ev % 8) : 3'd0,
             dex ? 7'(eh / 8) : 7'd0, dex ? 7'(ev / 8) : 7'd0,
             (n >= 960), 16'(fcx)};
      act = {pix_ce, hcount, vcount, de, hsync, vsync, line_start, frame_start,
             cell_col, glyph_row, text_col, text_row, irq, frame_cnt};
      if (frame_start) fs_cnt++;
      if (act !== exp) begin
        if (bad == 0) begin first_k = k; fa = act; fe = exp; end
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL frames_trace %0d bad cycles, first at clk %0d actual %h required %h", bad, first_k, fa, fe);
    end
    checks++;
    if (fs_cnt != 3) begin
      failures++;
      $display("FAIL frame_start_count actual %0d required 3", fs_cnt);
    end
    checks++;
    if (frame_cnt !== 16'd3 || irq !== 1'b1) begin
      failures++;
      $display("FAIL frames_end actual fc=%0d irq=%b required fc=3 irq=1", frame_cnt, irq);
    end
  endtask

  task automatic test_scale();
    bit ok;
    wait_pos(5, 3, ok); scale = 2'd1;
    wait_pos(16, 17, ok);
    checks++;
    if (!ok || {cell_col, glyph_row, text_col, text_row} !== {3'd0, 3'd1, 7'd2, 7'd2}) begin
      failures++;
      $display("FAIL scale_hold_x1 ok=%b actual %h required %h", ok, {cell_col, glyph_row, text_col, text_row}, {3'd0, 3'd1, 7'd2, 7'd2});
    end
    wait_pos(35, 17, ok);
    checks++;
    if (!ok || de !== 1'b0 || {cell_col, glyph_row, text_col, text_row} !== 20'd0) begin
      failures++;
      $display("FAIL blank_cells ok=%b actual de=%b cells=%h required de=0 cells=0", ok, de, {cell_col, glyph_row, text_col, text_row});
    end
    wait_pos(0, 0, ok);
    checks++;
    if (!ok || frame_start !== 1'b1 || line_start !== 1'b1) begin
      failures++;
      $display("FAIL frame_start_pulse ok=%b actual fs=%b ls=%b required 1 1", ok, frame_start, line_start);
    end
    wait_pos(13, 5, ok);
    checks++;
    if (!ok || {cell_col, glyph_row, text_col, text_row} !== {3'd6, 3'd2, 7'd0, 7'd0}) begin
      failures++;
      $display("FAIL scale_x2_13_5 ok=%b actual %h required %h", ok, {cell_col, glyph_row, text_col, text_row}, {3'd6, 3'd2, 7'd0, 7'd0});
    end
    wait_pos(16, 17, ok);
    checks++;
    if (!ok || {cell_col, glyph_row, text_col, text_row} !== {3'd0, 3'd0, 7'd1, 7'd1}) begin
      failures++;
      $display("FAIL scale_x2_16_17 ok=%b actual %h required %h", ok, {cell_col, glyph_row, text_col, text_row}, {3'd0, 3'd0, 7'd1, 7'd1});
    end
    scale = 2'd2;
    wait_pos(16, 17, ok);
    checks++;
    if (!ok || {cell_col, glyph_row, text_col, text_row} !== {3'd4, 3'd4, 7'd0, 7'd0}) begin
      failures++;
      $display("FAIL scale_x4 ok=%b actual %h required %h", ok, {cell_col, glyph_row, text_col, text_row}, {3'd4, 3'd4, 7'd0, 7'd0});
    end
    scale = 2'd3;
    wait_pos(16, 17, ok);
    checks++;
    if (!ok || {cell_col, glyph_row, text_col, text_row} !== {3'd0, 3'd1, 7'd2, 7'd2}) begin
      failures++;
      $display("FAIL scale_reserved ok=%b actual %h required %h", ok, {cell_col, glyph_row, text_col, text_row}, {3'd0, 3'd1, 7'd2, 7'd2});
    end
    scale = 2'd0;
  endtask

  task automatic test_irq();
    bit ok;
    @(negedge clk); rstn = 1'b0; en = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1; en = 1'b1;
    wait_pos(39, 23, ok);
    checks++;
    if (!ok || irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_before_vblank ok=%b actual %b required 0", ok, irq);
    end
    ack = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({pix_ce, hcount, vcount, irq, frame_cnt} !== {1'b1, 10'd0, 10'd24, 1'b1, 16'd1}) begin
      failures++;
      $display("FAIL irq_set_beats_ack actual ce=%b h=%0d v=%0d irq=%b fc=%0d required 1 0 24 1 1", pix_ce, hcount, vcount, irq, frame_cnt);
    end
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_ack_clear actual %b required 0", irq);
    end
    ack = 1'b0;
  endtask

  task automatic test_enable();
    bit ok;
    int bad;
    bad = 0;
    wait_pos(0, 24, ok);
    checks++;
    if (!ok || irq !== 1'b1 || frame_cnt !== 16'd2) begin
      failures++;
      $display("FAIL irq_second_frame ok=%b actual irq=%b fc=%0d required 1 2", ok, irq, frame_cnt);
    end
    wait_pos(20, 5, ok);
    en = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (pix_ce || line_start || frame_start || hcount !== 10'd20 || vcount !== 10'd5 || de !== 1'b1) bad++;
      if (i == 10) ack = 1'b1;
      if (i == 11) begin
        checks++;
        if (irq !== 1'b0) begin
          failures++;
          $display("FAIL ack_while_disabled actual %b required 0", irq);
        end
        ack = 1'b0;
      end
    end
    checks++;
    if (!ok || bad != 0) begin
      failures++;
      $display("FAIL enable_hold ok=%b bad cycles %0d required 0", ok, bad);
    end
    en = 1'b1;
    @(negedge clk);
    checks++;
    if (pix_ce !== 1'b0 || hcount !== 10'd20) begin
      failures++;
      $display("FAIL resume_early actual ce=%b h=%0d required 0 20", pix_ce, hcount);
    end
    @(negedge clk);
    checks++;
    if (pix_ce !== 1'b1 || hcount !== 10'd21) begin
      failures++;
      $display("FAIL resume actual ce=%b h=%0d required 1 21", pix_ce, hcount);
    end
  endtask

  task automatic test_reset_midline();
    bit ok;
    wait_pos(30, 8, ok);
    checks++;
    if (!ok || de !== 1'b1 || frame_cnt !== 16'd2) begin
      failures++;
      $display("FAIL pre_reset ok=%b actual de=%b fc=%0d required 1 2", ok, de, frame_cnt);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({hcount, vcount, pix_ce, de, hsync, vsync, irq, frame_cnt, cell_col, glyph_row, text_col, text_row} !==
        {10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 20'd0}) begin
      failures++;
      $display("FAIL async_reset actual h=%0d v=%0d ce=%b de=%b hs=%b vs=%b irq=%b fc=%0d cells=%h required reset values",
               hcount, vcount, pix_ce, de, hsync, vsync, irq, frame_cnt, {cell_col, glyph_row, text_col, text_row});
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (pix_ce !== 1'b0 || hcount !== 10'd0) begin
      failures++;
      $display("FAIL post_reset_wait actual ce=%b h=%0d required 0 0", pix_ce, hcount);
    end
    @(negedge clk);
    checks++;
    if ({pix_ce, hcount, vcount, frame_start, de} !== {1'b1, 10'd1, 10'd0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL post_reset_first actual ce=%b h=%0d v=%0d fs=%b de=%b required 1 1 0 0 1", pix_ce, hcount, vcount, frame_start, de);
    end
  endtask

  initial begin
    test_reset();
    test_frames();
    test_scale();
    test_irq();
    test_enable();
    test_reset_midline();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
